// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, state enum and decoded-op struct for muldiv_unit
package muldiv_pkg;

    // M-extension funct7 that routes an R-type op to this unit
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Decoded control bits for one op
    typedef struct packed {
        logic is_div;
        logic is_rem;
        logic a_signed;
        logic b_signed;
        logic take_high;
    } op_ctrl_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between the execute stage and muldiv_unit
interface muldiv_if #(
    parameter int XLEN         = 32,
    parameter int FUNCT3_WIDTH = 3
) ();
    logic                    start;
    logic [FUNCT3_WIDTH-1:0] funct3;
    logic [XLEN-1:0]         op_a;
    logic [XLEN-1:0]         op_b;
    logic                    flush;
    logic                    busy;
    logic                    done;
    logic [XLEN-1:0]         result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_op_decoder.sv
// rtl/muldiv_op_decoder.sv - funct3 to multiply/divide control bits
module muldiv_op_decoder
    import muldiv_pkg::*;
#(
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    output op_ctrl_t                ctrl
);

    // Map each M op onto divide/remainder select, operand signedness and product half
    always_comb begin
        ctrl = '0;
        case (funct3)
            OP_MUL:    ctrl = '{is_div: 1'b0, is_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b0};
            OP_MULH:   ctrl = '{is_div: 1'b0, is_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1, take_high: 1'b1};
            OP_MULHSU: ctrl = '{is_div: 1'b0, is_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b0, take_high: 1'b1};
            OP_MULHU:  ctrl = '{is_div: 1'b0, is_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b1};
            OP_DIV:    ctrl = '{is_div: 1'b1, is_rem: 1'b0, a_signed: 1'b1, b_signed: 1'b1, take_high: 1'b0};
            OP_DIVU:   ctrl = '{is_div: 1'b1, is_rem: 1'b0, a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b0};
            OP_REM:    ctrl = '{is_div: 1'b1, is_rem: 1'b1, a_signed: 1'b1, b_signed: 1'b1, take_high: 1'b0};
            OP_REMU:   ctrl = '{is_div: 1'b1, is_rem: 1'b1, a_signed: 1'b0, b_signed: 1'b0, take_high: 1'b0};
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M shift-add multiply / restoring divide unit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int CNT_WIDTH    = $clog2(XLEN) + 1
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam logic [XLEN-1:0]      MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(XLEN - 1);

    state_e               state, state_nxt;
    op_ctrl_t             dec;
    logic [CNT_WIDTH-1:0] count;
    logic                 is_div_q, is_rem_q, take_high_q, neg_q;
    logic [XLEN-1:0]      hi_q, lo_q, opnd_q, result_q;

    logic                 sign_a, sign_b, div_zero, div_ovf, fast;
    logic [XLEN-1:0]      mag_a, mag_b, fast_res;
    logic [XLEN:0]        mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]      hi_nxt, lo_nxt, div_val, calc_res, res_nxt;
    logic [2*XLEN-1:0]    prod, prod_s;
    logic                 load_op, step, load_res;

    muldiv_op_decoder #(.FUNCT3_WIDTH(FUNCT3_WIDTH)) u_dec (
        .funct3 (bus.funct3),
        .ctrl   (dec)
    );

    // Operand magnitudes and the special cases that bypass the iteration
    assign sign_a   = dec.a_signed & bus.op_a[XLEN-1];
    assign sign_b   = dec.b_signed & bus.op_b[XLEN-1];
    assign mag_a    = sign_a ? -bus.op_a : bus.op_a;
    assign mag_b    = sign_b ? -bus.op_b : bus.op_b;
    assign div_zero = dec.is_div & (bus.op_b == '0);
    assign div_ovf  = dec.is_div & dec.a_signed & (bus.op_a == MIN_NEG) & (bus.op_b == '1);
    assign fast     = div_zero | div_ovf;

    // Fixed results for divide-by-zero and signed overflow
    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = dec.is_rem ? bus.op_a : '1;
        end else begin
            fast_res = dec.is_rem ? '0 : MIN_NEG;
        end
    end

    // One radix-2 step: hi:lo is the product (multiply) or remainder:quotient (divide)
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        hi_nxt    = mul_sum[XLEN:1];
        lo_nxt    = {mul_sum[0], lo_q[XLEN-1:1]};
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and result selection from the last step's values
    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_s   = neg_q ? -prod : prod;
        div_val  = is_rem_q ? hi_nxt : lo_nxt;
        div_val  = neg_q ? -div_val : div_val;
        calc_res = take_high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        if (is_div_q) begin
            calc_res = div_val;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath enables; flush overrides everything
    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        step      = 1'b0;
        load_res  = 1'b0;
        res_nxt   = result_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load_op = 1'b1;
                    if (fast) begin
                        state_nxt = ST_FIN;
                        load_res  = 1'b1;
                        res_nxt   = fast_res;
                    end else begin
                        state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (count == LAST_ITER) begin
                    state_nxt = ST_FIN;
                    load_res  = 1'b1;
                    res_nxt   = calc_res;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = ST_IDLE;
            load_op   = 1'b0;
            step      = 1'b0;
            load_res  = 1'b0;
        end
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            is_div_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            take_high_q <= 1'b0;
            neg_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
        end else begin
            if (load_op) begin
                count       <= '0;
                is_div_q    <= dec.is_div;
                is_rem_q    <= dec.is_rem;
                take_high_q <= dec.take_high;
                neg_q       <= dec.is_rem ? sign_a : (sign_a ^ sign_b);
                hi_q        <= '0;
                lo_q        <= dec.is_div ? mag_a : mag_b;
                opnd_q      <= dec.is_div ? mag_b : mag_a;
            end else if (step) begin
                count <= count + 1'b1;
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
            end
            if (load_res) begin
                result_q <= res_nxt;
            end
        end
    end

    assign bus.busy   = (state == ST_CALC);
    assign bus.done   = (state == ST_FIN);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 1;
    localparam int LAT_FAST = 1;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] r;
        int              lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [XLEN-1:0] exp_q[$];
    vec_t vq[$];

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN), .FUNCT3_WIDTH(3)) bus ();

    muldiv_unit #(.XLEN(XLEN), .FUNCT3_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_r, input bit hold,
                         output int lat, output int busy_cyc, output logic [XLEN-1:0] res,
                         output logic prev_done);
        exp_q.push_back(exp_r);
        @(negedge clk);
        prev_done  = bus.done;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        lat        = 0;
        busy_cyc   = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.busy) busy_cyc++;
            if (bus.done) lat = k;
        end
        bus.start = 1'b0;
        res = bus.result;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst_n = 1'b1;
    endtask

    task automatic run_vq(input string tag);
        int lat, bc;
        logic [XLEN-1:0] res, exp_r;
        logic pd;
        while (vq.size() > 0) begin
            vec_t v;
            v = vq.pop_front();
            do_op(v.f3, v.a, v.b, v.r, 1'b0, lat, bc, res, pd);
            exp_r = exp_q.pop_front();
            checks++; if (res !== exp_r) begin errors++; $display("FAIL %s_result f3=%0d a=%h b=%h got=%h exp=%h", tag, v.f3, v.a, v.b, res, exp_r); end
            checks++; if (lat !== v.lat) begin errors++; $display("FAIL %s_latency f3=%0d got=%0d exp=%0d", tag, v.f3, lat, v.lat); end
            checks++; if (bc !== v.lat - 1) begin errors++; $display("FAIL %s_busy_cycles f3=%0d got=%0d exp=%0d", tag, v.f3, bc, v.lat - 1); end
        end
    endtask

    task automatic test_mul();
        vq.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM});
        vq.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NORM});
        vq.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM});
        vq.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NORM});
        run_vq("mul");
    endtask

    task automatic test_div();
        vq.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_NORM});
        vq.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NORM});
        vq.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        LAT_NORM});
        vq.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         LAT_NORM});
        run_vq("div");
    endtask

    task automatic test_special();
        vq.push_back('{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, LAT_FAST});
        vq.push_back('{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, LAT_FAST});
        vq.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST});
        vq.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_FAST});
        run_vq("special");
    endtask

    task automatic test_flush();
        int lat, bc, ndone;
        logic [XLEN-1:0] res, exp_r;
        logic pd;
        do_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, lat, bc, res, pd);
        exp_r = exp_q.pop_front();
        checks++; if (res !== exp_r) begin errors++; $display("FAIL flush_pre_result got=%h exp=%h", res, exp_r); end
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_result_kept got=%h exp=%h", bus.result, 32'd14); end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", ndone); end
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, lat, bc, res, pd);
        exp_r = exp_q.pop_front();
        checks++; if (res !== exp_r) begin errors++; $display("FAIL flush_after_result got=%h exp=%h", res, exp_r); end
        checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL flush_after_latency got=%0d exp=%0d", lat, LAT_NORM); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic [XLEN-1:0] res, exp_r;
        logic pd;
        do_op(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, lat, bc, res, pd);
        exp_r = exp_q.pop_front();
        checks++; if (res !== exp_r) begin errors++; $display("FAIL rstmid_pre_result got=%h exp=%h", res, exp_r); end
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd9; bus.op_b = 32'd9;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0, lat, bc, res, pd);
        exp_r = exp_q.pop_front();
        checks++; if (res !== exp_r) begin errors++; $display("FAIL rstmid_after_result got=%h exp=%h", res, exp_r); end
        checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL rstmid_after_latency got=%0d exp=%0d", lat, LAT_NORM); end
    endtask

    task automatic test_start_held();
        int lat, bc, ndone;
        logic [XLEN-1:0] res, exp_r;
        logic pd;
        do_op(3'b000, 32'd5, 32'd6, 32'd30, 1'b1, lat, bc, res, pd);
        exp_r = exp_q.pop_front();
        checks++; if (res !== exp_r) begin errors++; $display("FAIL held_result got=%h exp=%h", res, exp_r); end
        checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL held_latency got=%0d exp=%0d", lat, LAT_NORM); end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL held_extra_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [XLEN-1:0] a, b, res, exp_r;
        logic pd;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            do_op(3'b000, a, b, a * b, 1'b0, lat, bc, res, pd);
            exp_r = exp_q.pop_front();
            checks++; if (res !== exp_r) begin errors++; $display("FAIL b2b_result i=%0d got=%h exp=%h", i, res, exp_r); end
            checks++; if (lat !== LAT_NORM) begin errors++; $display("FAIL b2b_latency i=%0d got=%0d exp=%0d", i, lat, LAT_NORM); end
            if (i > 0) begin
                checks++; if (pd !== 1'b0) begin errors++; $display("FAIL b2b_done_width i=%0d got=%0b exp=0", i, pd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_start_held();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in XLEN. It is the sequential successor to the combinational ALU-select decoder.
- Decodes funct3 for the M extension (funct7 = 0000001), runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, then returns a registered result with a done pulse.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 4 and a power of 2.
- FUNCT3_WIDTH, 3, width of the funct3 field.
- CNT_WIDTH, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  FUNCT3_WIDTH  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 operand.
- op_b  input  XLEN  rs2 operand.
- flush  input  1  synchronous abort.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; held until the next done.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state goes to IDLE.
  - busy=0, done=0, result=0.
  - All internal registers are cleared.
  - If reset arrives mid-operation, the operation is discarded and no done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - On start=1, latch the decoded op, the operand magnitudes and the result-sign flags.
  - Normal case: go to CALC with count=0.
  - Fast path to FIN (1 cycle):
    - divide-by-zero (op_b=0) on DIV/DIVU/REM/REMU;
    - signed overflow on DIV/REM (op_a=MIN_NEG, op_b=all-ones).
- CALC:
  - One iteration per clock; count increments each cycle.
  - After XLEN iterations, go to FIN.
  - busy=1 throughout CALC.
  - start is ignored while not in IDLE.
- FIN:
  - done=1 for exactly one cycle.
  - result register is loaded on the edge entering FIN.
  - Next state is IDLE.
  - A start may be accepted in the cycle after FIN, i.e. back-to-back issue with one idle cycle.
- Latency, measured from the edge that samples start to the done cycle:
  - normal operation: XLEN+1 cycles;
  - fast path: 1 cycle.
- flush=1 in any state forces IDLE on the next edge:
  - done is suppressed;
  - result keeps its old value;
  - flush has priority over start and over the FIN transition.
- Signedness:
  - operands are converted to magnitudes per op (MULHSU: a signed, b unsigned);
  - the unsigned core computes a 2*XLEN-bit product, or a quotient and remainder;
  - the sign is applied after the last iteration.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special values:
  - Divide by zero: quotient = all-ones; remainder = op_a.
  - Signed overflow: quotient = MIN_NEG; remainder = 0.
- Arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). There are no exceptions.

Decomposition:
- muldiv_pkg holds:
  - funct3 op encodings (MUL..REMU);
  - the state enum IDLE/CALC/FIN;
  - the M-extension funct7 constant 7'b0000001.
- Sub-module muldiv_op_decoder (combinational): funct3 → {is_div, is_rem, a_signed, b_signed, take_high}.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan (XLEN=32):
- MUL, a=7, b=0xFFFFFFFD (-3) → done 33 cycles after start, result 0xFFFFFFEB; busy high for 32 cycles.
- MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 0x1234/0 → 0xFFFFFFFF, done 1 cycle after start. REM 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0, fast path.
- Interrupts mid-operation:
  - DIV started, flush at iteration 10 → IDLE next cycle, no done, result keeps its previous value.
  - rst_n low at iteration 20 → busy=0, result=0 immediately.
  - A new start after either interrupt completes correctly.
- Start handling:
  - start held high during CALC → ignored; exactly one done.
  - Back-to-back MULs issued on the cycle after each done → each result is correct and done pulses are one cycle wide.
